// File: rtl/stream_seq_checker.sv
// stream_seq_checker: receive-side consumer for the ftdi_245fifo read stream.
// Checks that accepted words form a wrap-around incrementing sequence and keeps
// saturating word/error counters, lock state, mismatch capture and the last byte.
// otready is either held high or driven from a free-running 16-bit LFSR.
module stream_seq_checker #(
  parameter int unsigned DSIZE        = 1,
  parameter int unsigned CNT_W        = 32,
  parameter int unsigned IDLE_TIMEOUT = 1000000
) (
  input  logic                 oclk,
  input  logic                 rst_n,
  input  logic                 otvalid,
  output logic                 otready,
  input  logic [8*DSIZE-1:0]   otdata,
  input  logic                 clear,
  input  logic                 throttle,
  output logic                 locked,
  output logic [CNT_W-1:0]     word_cnt,
  output logic [CNT_W-1:0]     err_cnt,
  output logic                 err_flag,
  output logic [8*DSIZE-1:0]   exp_data,
  output logic [8*DSIZE-1:0]   got_data,
  output logic [7:0]           last_data
);

  localparam int unsigned DW = 8 * DSIZE;
  localparam int unsigned IW = $clog2(IDLE_TIMEOUT + 1);

  localparam logic [DW-1:0]    DATA_ONE  = DW'(1);
  localparam logic [CNT_W-1:0] CNT_ONE   = CNT_W'(1);
  localparam logic [IW-1:0]    IDLE_ONE  = IW'(1);
  // Timeout fires on the edge where the counter would reach IDLE_TIMEOUT.
  localparam logic [IW-1:0]    IDLE_LAST = IW'(IDLE_TIMEOUT - 1);

  typedef enum logic {
    HUNT   = 1'b0,
    LOCKED = 1'b1
  } state_e;

  state_e            state_q,  state_d;
  logic [15:0]       lfsr_q,   lfsr_d;
  logic              ready_q,  ready_d;
  logic [DW-1:0]     expect_q, expect_d;
  logic [IW-1:0]     idle_q,   idle_d;
  logic [CNT_W-1:0]  word_q,   word_d;
  logic [CNT_W-1:0]  err_q,    err_d;
  logic              flag_q,   flag_d;
  logic [DW-1:0]     expd_q,   expd_d;
  logic [DW-1:0]     gotd_q,   gotd_d;
  logic [7:0]        last_q,   last_d;
  logic              accept;

  assign accept = otvalid & ready_q;

  // Next-state: LFSR/otready free-run; clear beats accept, accept beats idle timeout.
  always_comb begin
    lfsr_d   = {lfsr_q[0] ^ lfsr_q[2] ^ lfsr_q[3] ^ lfsr_q[5], lfsr_q[15:1]};
    ready_d  = throttle ? lfsr_q[0] : 1'b1;
    state_d  = state_q;
    expect_d = expect_q;
    idle_d   = idle_q;
    word_d   = word_q;
    err_d    = err_q;
    flag_d   = flag_q;
    expd_d   = expd_q;
    gotd_d   = gotd_q;
    last_d   = last_q;

    if (clear) begin
      state_d  = HUNT;
      expect_d = '0;
      idle_d   = '0;
      word_d   = '0;
      err_d    = '0;
      flag_d   = 1'b0;
      expd_d   = '0;
      gotd_d   = '0;
    end else if (accept) begin
      state_d  = LOCKED;
      expect_d = otdata + DATA_ONE;
      idle_d   = '0;
      last_d   = otdata[7:0];
      if (word_q != '1) begin
        word_d = word_q + CNT_ONE;
      end
      if (state_q == LOCKED && otdata != expect_q) begin
        flag_d = 1'b1;
        expd_d = expect_q;
        gotd_d = otdata;
        if (err_q != '1) begin
          err_d = err_q + CNT_ONE;
        end
      end
    end else if (state_q == LOCKED) begin
      if (idle_q == IDLE_LAST) begin
        state_d = HUNT;
        idle_d  = '0;
      end else begin
        idle_d  = idle_q + IDLE_ONE;
      end
    end else begin
      idle_d = '0;
    end
  end

  // State register with asynchronous active-low reset.
  always_ff @(posedge oclk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= HUNT;
      lfsr_q   <= 16'hACE1;
      ready_q  <= 1'b0;
      expect_q <= '0;
      idle_q   <= '0;
      word_q   <= '0;
      err_q    <= '0;
      flag_q   <= 1'b0;
      expd_q   <= '0;
      gotd_q   <= '0;
      last_q   <= '0;
    end else begin
      state_q  <= state_d;
      lfsr_q   <= lfsr_d;
      ready_q  <= ready_d;
      expect_q <= expect_d;
      idle_q   <= idle_d;
      word_q   <= word_d;
      err_q    <= err_d;
      flag_q   <= flag_d;
      expd_q   <= expd_d;
      gotd_q   <= gotd_d;
      last_q   <= last_d;
    end
  end

  assign otready   = ready_q;
  assign locked    = (state_q == LOCKED);
  assign word_cnt  = word_q;
  assign err_cnt   = err_q;
  assign err_flag  = flag_q;
  assign exp_data  = expd_q;
  assign got_data  = gotd_q;
  assign last_data = last_q;

endmodule

// File: tb/tb_stream_seq_checker.sv
// Testbench for stream_seq_checker: table-driven per-cycle vectors plus
// hand-written sequences for long streams, saturation, async reset and throttle.
module tb_stream_seq_checker;

  logic        oclk = 1'b0;
  logic        rst_n;
  logic        otvalid;
  logic [7:0]  otdata;
  logic        clear;
  logic        throttle;

  logic        otready, locked, err_flag;
  logic [31:0] word_cnt, err_cnt;
  logic [7:0]  exp_data, got_data, last_data;

  logic        s_otready, s_locked, s_err_flag;
  logic [2:0]  s_word_cnt, s_err_cnt;
  logic [7:0]  s_exp_data, s_got_data, s_last_data;

  int checks = 0;
  int errors = 0;

  always #5 oclk = ~oclk;

  stream_seq_checker #(.DSIZE(1), .CNT_W(32), .IDLE_TIMEOUT(8)) dut (
    .oclk(oclk), .rst_n(rst_n), .otvalid(otvalid), .otready(otready),
    .otdata(otdata), .clear(clear), .throttle(throttle), .locked(locked),
    .word_cnt(word_cnt), .err_cnt(err_cnt), .err_flag(err_flag),
    .exp_data(exp_data), .got_data(got_data), .last_data(last_data)
  );

  // Narrow-counter instance to exercise saturation.
  stream_seq_checker #(.DSIZE(1), .CNT_W(3), .IDLE_TIMEOUT(8)) dut_sat (
    .oclk(oclk), .rst_n(rst_n), .otvalid(otvalid), .otready(s_otready),
    .otdata(otdata), .clear(clear), .throttle(throttle), .locked(s_locked),
    .word_cnt(s_word_cnt), .err_cnt(s_err_cnt), .err_flag(s_err_flag),
    .exp_data(s_exp_data), .got_data(s_got_data), .last_data(s_last_data)
  );

  typedef struct {
    logic        clr;
    logic        vld;
    logic [7:0]  d;
    logic        lk;
    logic [31:0] wc;
    logic [31:0] ec;
    logic        fl;
    logic [7:0]  xd;
    logic [7:0]  gd;
    logic [7:0]  ld;
  } vec_t;

  vec_t vt[$];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, req);
    end
  endtask

  task automatic addv(input logic clr, input logic vld, input logic [7:0] d,
                      input logic lk, input logic [31:0] wc, input logic [31:0] ec,
                      input logic fl, input logic [7:0] xd, input logic [7:0] gd,
                      input logic [7:0] ld);
    vec_t v;
    v.clr = clr; v.vld = vld; v.d = d; v.lk = lk; v.wc = wc; v.ec = ec;
    v.fl = fl; v.xd = xd; v.gd = gd; v.ld = ld;
    vt.push_back(v);
  endtask

  // Drive one cycle of inputs at the negedge, sample after the next posedge.
  task automatic cyc(input logic clr, input logic vld, input logic [7:0] d);
    clear   = clr;
    otvalid = vld;
    otdata  = d;
    @(posedge oclk);
    @(negedge oclk);
  endtask

  function automatic logic [15:0] lfsr_step(input logic [15:0] s);
    return {s[0] ^ s[2] ^ s[3] ^ s[5], s[15:1]};
  endfunction

  initial begin
    int          not_ready;
    int          ones;
    int          rdy_bad;
    int          wc_bad;
    logic [15:0] m;
    logic        pred;
    logic        prev;

    rst_n = 1'b0; otvalid = 1'b0; otdata = '0; clear = 1'b0; throttle = 1'b0;

    // Reset values while reset is held.
    #3;
    chk("rst_otready", {31'd0, otready}, 32'd0);
    chk("rst_locked",  {31'd0, locked}, 32'd0);
    chk("rst_word",    word_cnt, 32'd0);
    chk("rst_err",     err_cnt, 32'd0);
    chk("rst_flag",    {31'd0, err_flag}, 32'd0);
    chk("rst_last",    {24'd0, last_data}, 32'd0);

    @(negedge oclk);
    rst_n = 1'b1;
    chk("rel_otready0", {31'd0, otready}, 32'd0);
    cyc(1'b0, 1'b0, 8'h00);
    chk("rel_otready1", {31'd0, otready}, 32'd1);

    // 300 words back-to-back.
    not_ready = 0;
    for (int i = 0; i < 300; i++) begin
      cyc(1'b0, 1'b1, 8'(i));
      if (otready !== 1'b1) not_ready++;
    end
    otvalid = 1'b0;
    chk("s300_notready", not_ready, 0);
    chk("s300_word",   word_cnt, 32'd300);
    chk("s300_err",    err_cnt, 32'd0);
    chk("s300_locked", {31'd0, locked}, 32'd1);
    chk("s300_last",   {24'd0, last_data}, 32'h2B);
    chk("s300_satwc",  {29'd0, s_word_cnt}, 32'd7);

    // clr vld d | locked word err flag exp got last
    addv(1, 0, 8'h00, 0, 0, 0, 0, 8'h00, 8'h00, 8'h2B);
    addv(0, 1, 8'hFE, 1, 1, 0, 0, 8'h00, 8'h00, 8'hFE);
    addv(0, 1, 8'hFF, 1, 2, 0, 0, 8'h00, 8'h00, 8'hFF);
    addv(0, 1, 8'h00, 1, 3, 0, 0, 8'h00, 8'h00, 8'h00);
    addv(0, 1, 8'h01, 1, 4, 0, 0, 8'h00, 8'h00, 8'h01);
    addv(1, 0, 8'h00, 0, 0, 0, 0, 8'h00, 8'h00, 8'h01);
    addv(0, 1, 8'h05, 1, 1, 0, 0, 8'h00, 8'h00, 8'h05);
    addv(0, 1, 8'h06, 1, 2, 0, 0, 8'h00, 8'h00, 8'h06);
    addv(0, 1, 8'h09, 1, 3, 1, 1, 8'h07, 8'h09, 8'h09);
    addv(0, 1, 8'h0A, 1, 4, 1, 1, 8'h07, 8'h09, 8'h0A);
    addv(0, 1, 8'h0B, 1, 5, 1, 1, 8'h07, 8'h09, 8'h0B);
    addv(1, 0, 8'h00, 0, 0, 0, 0, 8'h00, 8'h00, 8'h0B);
    addv(0, 1, 8'h03, 1, 1, 0, 0, 8'h00, 8'h00, 8'h03);
    for (int i = 0; i < 7; i++) addv(0, 0, 8'h00, 1, 1, 0, 0, 8'h00, 8'h00, 8'h03);
    addv(0, 0, 8'h00, 0, 1, 0, 0, 8'h00, 8'h00, 8'h03);
    addv(0, 1, 8'h32, 1, 2, 0, 0, 8'h00, 8'h00, 8'h32);
    addv(0, 1, 8'h33, 1, 3, 0, 0, 8'h00, 8'h00, 8'h33);
    addv(0, 1, 8'h34, 1, 4, 0, 0, 8'h00, 8'h00, 8'h34);
    addv(1, 1, 8'h14, 0, 0, 0, 0, 8'h00, 8'h00, 8'h34);
    addv(0, 1, 8'h4D, 1, 1, 0, 0, 8'h00, 8'h00, 8'h4D);
    addv(0, 1, 8'h4E, 1, 2, 0, 0, 8'h00, 8'h00, 8'h4E);

    foreach (vt[i]) begin
      cyc(vt[i].clr, vt[i].vld, vt[i].d);
      chk($sformatf("v%0d_ready", i), {31'd0, otready}, 32'd1);
      chk($sformatf("v%0d_locked", i), {31'd0, locked}, {31'd0, vt[i].lk});
      chk($sformatf("v%0d_word", i), word_cnt, vt[i].wc);
      chk($sformatf("v%0d_err", i), err_cnt, vt[i].ec);
      chk($sformatf("v%0d_flag", i), {31'd0, err_flag}, {31'd0, vt[i].fl});
      chk($sformatf("v%0d_exp", i), {24'd0, exp_data}, {24'd0, vt[i].xd});
      chk($sformatf("v%0d_got", i), {24'd0, got_data}, {24'd0, vt[i].gd});
      chk($sformatf("v%0d_last", i), {24'd0, last_data}, {24'd0, vt[i].ld});
    end

    // Saturation: every word after the first mismatches.
    cyc(1'b1, 1'b0, 8'h00);
    for (int i = 0; i < 10; i++) cyc(1'b0, 1'b1, 8'(2 * i));
    otvalid = 1'b0;
    chk("sat_main_word", word_cnt, 32'd10);
    chk("sat_main_err",  err_cnt, 32'd9);
    chk("sat_main_exp",  {24'd0, exp_data}, 32'h11);
    chk("sat_main_got",  {24'd0, got_data}, 32'h12);
    chk("sat_word",      {29'd0, s_word_cnt}, 32'd7);
    chk("sat_err",       {29'd0, s_err_cnt}, 32'd7);
    chk("sat_flag",      {31'd0, s_err_flag}, 32'd1);

    // Asynchronous reset mid-cycle.
    #2;
    rst_n = 1'b0;
    #1;
    chk("arst_otready", {31'd0, otready}, 32'd0);
    chk("arst_locked",  {31'd0, locked}, 32'd0);
    chk("arst_word",    word_cnt, 32'd0);
    chk("arst_err",     err_cnt, 32'd0);
    chk("arst_flag",    {31'd0, err_flag}, 32'd0);
    chk("arst_expgot",  {16'd0, exp_data, got_data}, 32'd0);
    chk("arst_last",    {24'd0, last_data}, 32'd0);

    // Throttled back-pressure from reset, otvalid held high.
    @(negedge oclk);
    throttle = 1'b1;
    otvalid  = 1'b1;
    otdata   = 8'h00;
    rst_n    = 1'b1;
    m = 16'hACE1; ones = 0; rdy_bad = 0; wc_bad = 0; prev = 1'b0;
    for (int k = 0; k < 1000; k++) begin
      otdata = 8'(ones);
      if (prev) ones++;
      pred = m[0];
      m = lfsr_step(m);
      @(posedge oclk);
      @(negedge oclk);
      if (otready !== pred) rdy_bad++;
      if (word_cnt !== 32'(ones)) wc_bad++;
      prev = pred;
    end
    chk("thr_ready_seq", rdy_bad, 0);
    chk("thr_word_step", wc_bad, 0);
    chk("thr_word",      word_cnt, 32'(ones));
    chk("thr_err",       err_cnt, 32'd0);

    // throttle=0 forces otready high one cycle later.
    cyc(1'b0, 1'b0, 8'h00);
    throttle = 1'b0;
    pred = m[0];
    cyc(1'b0, 1'b0, 8'h00);
    chk("thr_off_ready", {31'd0, otready}, 32'd1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
